// File: rtl/ram_sp_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// ram_sp_fifo_ctrl
//
// FIFO controller sitting in front of a 16x8 single-port RAM with a registered
// read address (read data appears one cycle after the address is presented).
// The controller owns the RAM's only port and shares it between pushes
// (writes) and refills of the output register (reads).
//
// Arbitration: a write normally wins the port, but once a write has gone
// through while a read was wanted, the read gets priority. The pending read
// then blocks the push side for one cycle. On contention at most one write
// passes before the waiting read issues.
//
// Read path: issue (address out) -> pending (RAM data valid) -> captured into
// out_data/out_valid. A new read is only requested once the output register
// is empty and no read is in flight. This caps throughput at one word per
// three cycles but keeps in_ready free of any path from in_valid/out_ready.
//
// Optional build macro FIFO_STATUS_EN adds the level and almost_full ports
// (and the AFULL_TH parameter). Without it those ports do not exist.
//
// Ports
//   clk           rising-edge clock
//   rst_n         synchronous active-low reset (RAM contents are not cleared)
//   in_data       push word
//   in_valid      push request
//   in_ready      push accepted when in_valid && in_ready
//   out_data      registered pop word
//   out_valid     out_data holds a word
//   out_ready     pop when out_valid && out_ready
//   ram_address   RAM address
//   ram_data_in   RAM write data
//   ram_write_en  RAM write enable, active high
//   ram_data_out  RAM read data, valid one cycle after its address
//   level         words held: RAM + in flight + output register (FIFO_STATUS_EN)
//   almost_full   level >= AFULL_TH (FIFO_STATUS_EN)
// -----------------------------------------------------------------------------
module ram_sp_fifo_ctrl #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 4
`ifdef FIFO_STATUS_EN
    ,
    parameter int AFULL_TH = 12
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data_in,
    output logic              ram_write_en,
    input  logic [DATA_W-1:0] ram_data_out
`ifdef FIFO_STATUS_EN
    ,
    output logic [ADDR_W:0]   level,
    output logic              almost_full
`endif
);

    localparam logic [ADDR_W:0]   CNT_ZERO = {(ADDR_W+1){1'b0}};
    localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   CNT_FULL = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W-1:0] PTR_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

    logic [ADDR_W-1:0] wr_ptr_r;
    logic [ADDR_W-1:0] rd_ptr_r;
    logic [ADDR_W:0]   ram_count_r;
    logic              rd_pending_r;
    logic              out_valid_r;
    logic [DATA_W-1:0] out_data_r;
    logic              prio_rd_r;

    logic              rd_want_s;
    logic              in_ready_s;
    logic              wr_s;
    logic              rd_iss_s;

    // Port arbitration: decide write vs read issue from registered state only.
    always_comb begin
        rd_want_s  = (ram_count_r != CNT_ZERO) && !rd_pending_r && !out_valid_r;
        in_ready_s = (ram_count_r != CNT_FULL) && !(rd_want_s && prio_rd_r);
        // Writes are suppressed while in reset so the RAM is never disturbed
        // by a push presented during reset.
        wr_s       = in_valid && in_ready_s && rst_n;
        rd_iss_s   = rd_want_s && !wr_s;
    end

    // RAM port drive: write address on a write, otherwise the read pointer.
    always_comb begin
        ram_data_in = in_data;
        if (wr_s) begin
            ram_write_en = 1'b1;
            ram_address  = wr_ptr_r;
        end else begin
            ram_write_en = 1'b0;
            ram_address  = rd_ptr_r;
        end
    end

    // Output port drive from internal state.
    always_comb begin
        in_ready  = in_ready_s;
        out_data  = out_data_r;
        out_valid = out_valid_r;
    end

    // Write and read pointers; both wrap naturally at the RAM depth.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
        end else begin
            if (wr_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (rd_iss_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

    // Occupancy of the RAM; write and read issue are mutually exclusive.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ram_count_r <= CNT_ZERO;
        end else begin
            case ({wr_s, rd_iss_s})
                2'b10:   ram_count_r <= ram_count_r + CNT_ONE;
                2'b01:   ram_count_r <= ram_count_r - CNT_ONE;
                default: ram_count_r <= ram_count_r;
            endcase
        end
    end

    // Read in flight: set on issue, cleared when the RAM data is captured.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_pending_r <= 1'b0;
        end else if (rd_iss_s) begin
            rd_pending_r <= 1'b1;
        end else begin
            rd_pending_r <= 1'b0;
        end
    end

    // Output register: capture RAM data, drop valid on pop.
    // A capture can only happen while out_valid is low, so it never meets a pop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_data_r  <= DATA_ZERO;
            out_valid_r <= 1'b0;
        end else if (rd_pending_r) begin
            out_data_r  <= ram_data_out;
            out_valid_r <= 1'b1;
        end else if (out_valid_r && out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

    // Fairness flag: a write that overtook a wanted read hands priority to the read.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prio_rd_r <= 1'b0;
        end else if (rd_iss_s) begin
            prio_rd_r <= 1'b0;
        end else if (wr_s && rd_want_s) begin
            prio_rd_r <= 1'b1;
        end
    end

`ifdef FIFO_STATUS_EN
    localparam logic [ADDR_W:0]   LEVEL_MAX = {(ADDR_W+1){1'b1}};
    localparam logic [ADDR_W:0]   AFULL_LVL = AFULL_TH[ADDR_W:0];

    logic [ADDR_W+1:0] level_sum_s;
    logic [ADDR_W:0]   level_s;

    // Total words held, saturated to the width of the level port.
    always_comb begin
        level_sum_s = {1'b0, ram_count_r}
                    + {{(ADDR_W+1){1'b0}}, rd_pending_r}
                    + {{(ADDR_W+1){1'b0}}, out_valid_r};
        if (level_sum_s > {1'b0, LEVEL_MAX}) begin
            level_s = LEVEL_MAX;
        end else begin
            level_s = level_sum_s[ADDR_W:0];
        end
        level       = level_s;
        almost_full = (level_s >= AFULL_LVL);
    end
`endif

endmodule

// File: tb/tb_ram_sp_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// tb_ram_sp_fifo_ctrl
//
// Directed bench for ram_sp_fifo_ctrl with a behavioural 16x8 single-port RAM
// (registered read address). Accepted pushes go into a scoreboard queue and
// every pop is compared against the queue head. Signals are sampled 1 time
// unit after the falling edge; inputs change on the falling edge.
// -----------------------------------------------------------------------------
module tb_ram_sp_fifo_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] ram_address;
    logic [7:0] ram_data_in;
    logic       ram_write_en;
    logic [7:0] ram_data_out;
`ifdef FIFO_STATUS_EN
    logic [4:0] level;
    logic       almost_full;
`endif

    ram_sp_fifo_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .ram_address  (ram_address),
        .ram_data_in  (ram_data_in),
        .ram_write_en (ram_write_en),
        .ram_data_out (ram_data_out)
`ifdef FIFO_STATUS_EN
        ,
        .level        (level),
        .almost_full  (almost_full)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural RAM: synchronous write, registered read address.
    logic [7:0] mem [16];
    logic [3:0] ram_addr_q;
    always @(posedge clk) begin
        if (ram_write_en) mem[ram_address] <= ram_data_in;
        ram_addr_q <= ram_address;
    end
    assign ram_data_out = mem[ram_addr_q];

    int         n_chk = 0;
    int         n_fail = 0;
    int         n_pop = 0;
    int         cyc = 0;
    int         wr_run = 0;
    int         max_wr_run = 0;
    logic       acc_f;
    logic [7:0] sb [$];
    int         pop_cyc [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: sample handshakes, update scoreboard, advance to next negedge.
    task automatic tick();
        logic [7:0] e;
        #1;
        acc_f = 1'b0;
        if (rst_n && in_valid && in_ready === 1'b1) begin
            sb.push_back(in_data);
            acc_f = 1'b1;
        end
        if (rst_n && out_valid === 1'b1 && out_ready) begin
            n_pop++;
            pop_cyc.push_back(cyc);
            if (sb.size() == 0) begin
                chk("pop_unexpected", 32'(sb.size()), 32'd1);
            end else begin
                e = sb.pop_front();
                chk("pop_data", {24'd0, out_data}, {24'd0, e});
            end
        end
        if (ram_write_en === 1'b1) wr_run++;
        else wr_run = 0;
        if (wr_run > max_wr_run) max_wr_run = wr_run;
        cyc++;
        @(negedge clk);
    endtask

    task automatic push_n(input int n, input logic [7:0] base, input logic [7:0] stride);
        int k = 0;
        int g = 0;
        in_valid = 1'b1;
        while (k < n && g < 2000) begin
            in_data = base + 8'(k) * stride;
            tick();
            if (acc_f) k++;
            g++;
        end
        in_valid = 1'b0;
        chk("push_count", 32'(k), 32'(n));
    endtask

    task automatic wait_pops(input int target);
        int g = 0;
        while (n_pop < target && g < 2000) begin
            tick();
            g++;
        end
        chk("pop_count", 32'(n_pop), 32'(target));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int lat;

        // 1. Reset held two cycles with a push presented.
        rst_n = 1'b0; in_valid = 1'b1; in_data = 8'h5A; out_ready = 1'b0;
        @(negedge clk);
        tick();
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_ram_we", {31'd0, ram_write_en}, 32'd0);
        chk("rst_out_data", {24'd0, out_data}, 32'd0);
`ifdef FIFO_STATUS_EN
        chk("rst_level", {27'd0, level}, 32'd0);
`endif
        rst_n = 1'b1; in_valid = 1'b0;
        tick();

        // 2. Ordering: three back-to-back pushes, pops spaced 3 cycles.
        out_ready = 1'b1;
        pop_cyc.delete();
        push_n(3, 8'h11, 8'h11);
        wait_pops(3);
        chk("sb_empty_t2", 32'(sb.size()), 32'd0);
        chk("pop_gap_1", 32'(pop_cyc[1] - pop_cyc[0]), 32'd3);
        chk("pop_gap_2", 32'(pop_cyc[2] - pop_cyc[1]), 32'd3);

        // 3. Full: 17 words with pop side stalled, pointers wrap.
        out_ready = 1'b0;
        base = n_pop;
        push_n(17, 8'h00, 8'h01);
        repeat (3) tick();
        chk("full_in_ready", {31'd0, in_ready}, 32'd0);
        chk("full_out_valid", {31'd0, out_valid}, 32'd1);
        chk("full_out_data", {24'd0, out_data}, 32'd0);
`ifdef FIFO_STATUS_EN
        chk("full_level", {27'd0, level}, 32'd17);
`endif
        out_ready = 1'b1;
        wait_pops(base + 17);
        chk("sb_empty_t3", 32'(sb.size()), 32'd0);
        chk("empty_in_ready", {31'd0, in_ready}, 32'd1);

        // 4. Contention: push held valid, pop always ready, 100 words.
        max_wr_run = 0; wr_run = 0;
        base = n_pop;
        push_n(100, 8'h03, 8'h07);
        wait_pops(base + 100);
        chk("sb_empty_t4", 32'(sb.size()), 32'd0);
        chk("wr_run_le3", {31'd0, (max_wr_run <= 3)}, 32'd1);

        // 5. Reset mid-operation discards stored data.
        out_ready = 1'b0;
        push_n(5, 8'h40, 8'h01);
        repeat (4) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        sb.delete();
        chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1; in_data = 8'hA5;
        tick();
        chk("post_rst_accept", {31'd0, acc_f}, 32'd1);
        in_valid = 1'b0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        chk("latency", 32'(lat), 32'd3);
        base = n_pop;
        out_ready = 1'b1;
        wait_pops(base + 1);
        chk("sb_empty_t5", 32'(sb.size()), 32'd0);

`ifdef FIFO_STATUS_EN
        // 6. Status: level and almost_full around the threshold.
        out_ready = 1'b0;
        base = n_pop;
        push_n(12, 8'h60, 8'h01);
        repeat (5) tick();
        chk("level_12", {27'd0, level}, 32'd12);
        chk("afull_12", {31'd0, almost_full}, 32'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("level_11", {27'd0, level}, 32'd11);
        chk("afull_11", {31'd0, almost_full}, 32'd0);
        out_ready = 1'b1;
        wait_pops(base + 12);
        chk("sb_empty_t6", 32'(sb.size()), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
